// File: rtl/exec_wb.sv
// -----------------------------------------------------------------------------
// exec_wb : execute / write-back stage sitting directly after the register file.
//
// Takes the two read operands (a, b) and the accumulator (acc). Drives the
// register-file write port (wr_en / wr_addr / wr_data) and keeps the carry and
// zero flags that the branch logic uses.
//   - ADD, SUB, AND, XOR, SHL, SHR, MOVACC run in a single cycle: one write
//     in the WB state.
//   - MUL is an unsigned shift-add multiply that retires one multiplier bit
//     per cycle (W cycles in total). It writes the low product byte to dst
//     (WB_LO) and then the high byte to the accumulator index (WB_HI).
//
// Ports
//   clk      in   system clock, every state update happens on posedge
//   reset    in   synchronous active-high reset
//   start    in   issue pulse; it is only looked at in IDLE
//   op       in   3-bit opcode (000 ADD .. 110 MUL, 111 MOVACC)
//   dst      in   destination register index
//   a, b     in   register-file read operands
//   acc      in   accumulator read value
//   busy     out  high whenever the FSM is not in IDLE
//   done     out  one-cycle pulse on the final write-back of an op
//   wr_en    out  register-file write enable
//   wr_addr  out  register-file write address (holds its value between writes)
//   wr_data  out  register-file write data (holds its value between writes)
//   carry    out  carry flag, updated only on the cycle where done=1
//   zero     out  zero flag, updated only on the cycle where done=1
// Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module exec_wb #(
  parameter int W        = 8,
  parameter int AW       = 4,
  parameter int ACC_ADDR = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [AW-1:0] dst,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [W-1:0]  acc,
  output logic          busy,
  output logic          done,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [W-1:0]  wr_data,
  output logic          carry,
  output logic          zero
);

  localparam int CW = $clog2(W + 1);
  localparam logic [AW-1:0] ACC_IDX = AW'(ACC_ADDR);

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_AND    = 3'b010;
  localparam logic [2:0] OP_XOR    = 3'b011;
  localparam logic [2:0] OP_SHL    = 3'b100;
  localparam logic [2:0] OP_SHR    = 3'b101;
  localparam logic [2:0] OP_MUL    = 3'b110;
  localparam logic [2:0] OP_MOVACC = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WB    = 3'd1,
    S_MUL   = 3'd2,
    S_WB_LO = 3'd3,
    S_WB_HI = 3'd4
  } state_t;

  state_t          state_r, state_n;
  logic            busy_r, busy_n;
  logic            done_r, done_n;
  logic            wr_en_r, wr_en_n;
  logic [AW-1:0]   wr_addr_r, wr_addr_n;
  logic [W-1:0]    wr_data_r, wr_data_n;
  logic            carry_r, carry_n;
  logic            zero_r, zero_n;

  // Operands latched at issue for the multi-cycle multiply.
  logic [AW-1:0]   dst_r, dst_n;
  logic [W-1:0]    a_r, a_n;
  logic [W-1:0]    b_r, b_n;
  logic [2*W-1:0]  prod_r, prod_n;
  logic [CW-1:0]   cnt_r, cnt_n;

  logic [W:0]      add_s;
  logic [W:0]      sub_s;
  logic [W-1:0]    alu_res_s;
  logic            alu_c_s;
  logic [W:0]      mul_sum_s;
  logic [2*W-1:0]  mul_step_s;

  // Bit W of the subtract is the borrow out, which is set exactly when a < b (unsigned).
  assign add_s = {1'b0, a} + {1'b0, b};
  assign sub_s = {1'b0, a} - {1'b0, b};

  // One shift-add step. Add the multiplicand into the upper half when the
  // current multiplier LSB is set, then shift the whole product right by one.
  // The carry out of the add becomes the new top bit.
  assign mul_sum_s  = {1'b0, prod_r[2*W-1:W]} + (b_r[0] ? {1'b0, a_r} : {(W+1){1'b0}});
  assign mul_step_s = {mul_sum_s, prod_r[W-1:1]};

  // Single-cycle ALU result and carry, computed from the operands on the issue cycle.
  always_comb begin
    alu_res_s = {W{1'b0}};
    alu_c_s   = carry_r;
    case (op)
      OP_ADD:    begin alu_res_s = add_s[W-1:0];     alu_c_s = add_s[W];  end
      OP_SUB:    begin alu_res_s = sub_s[W-1:0];     alu_c_s = sub_s[W];  end
      OP_AND:    begin alu_res_s = a & b;            alu_c_s = 1'b0;      end
      OP_XOR:    begin alu_res_s = a ^ b;            alu_c_s = 1'b0;      end
      OP_SHL:    begin alu_res_s = {a[W-2:0], 1'b0}; alu_c_s = a[W-1];    end
      OP_SHR:    begin alu_res_s = {1'b0, a[W-1:1]}; alu_c_s = a[0];      end
      OP_MOVACC: begin alu_res_s = acc;              alu_c_s = carry_r;   end
      default:   begin alu_res_s = {W{1'b0}};        alu_c_s = carry_r;   end
    endcase
  end

  // Next-state and next-output logic. Every output is computed here one cycle
  // early and then registered, so the values are seen in the cycle after the
  // deciding edge.
  always_comb begin
    state_n   = state_r;
    done_n    = 1'b0;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr_r;
    wr_data_n = wr_data_r;
    carry_n   = carry_r;
    zero_n    = zero_r;
    dst_n     = dst_r;
    a_n       = a_r;
    b_n       = b_r;
    prod_n    = prod_r;
    cnt_n     = cnt_r;

    case (state_r)
      S_IDLE: begin
        if (start) begin
          dst_n = dst;
          a_n   = a;
          b_n   = b;
          if (op == OP_MUL) begin
            prod_n  = {(2*W){1'b0}};
            cnt_n   = CW'(W);
            state_n = S_MUL;
          end else begin
            // ALU ops are resolved right away; the WB cycle shows the result.
            state_n   = S_WB;
            wr_en_n   = 1'b1;
            wr_addr_n = dst;
            wr_data_n = alu_res_s;
            done_n    = 1'b1;
            carry_n   = alu_c_s;
            zero_n    = (alu_res_s == {W{1'b0}});
          end
        end else begin
          state_n = S_IDLE;
        end
      end

      S_WB: begin
        state_n = S_IDLE;
      end

      S_MUL: begin
        prod_n = mul_step_s;
        b_n    = {1'b0, b_r[W-1:1]};
        cnt_n  = cnt_r - CW'(1);
        if (cnt_r == CW'(1)) begin
          // Last iteration: take the low byte from the freshly stepped product.
          state_n   = S_WB_LO;
          wr_en_n   = 1'b1;
          wr_addr_n = dst_r;
          wr_data_n = mul_step_s[W-1:0];
        end else begin
          state_n = S_MUL;
        end
      end

      S_WB_LO: begin
        state_n   = S_WB_HI;
        wr_en_n   = 1'b1;
        wr_addr_n = ACC_IDX;
        wr_data_n = prod_r[2*W-1:W];
        done_n    = 1'b1;
        carry_n   = (prod_r[2*W-1:W] != {W{1'b0}});
        zero_n    = (prod_r == {(2*W){1'b0}});
      end

      S_WB_HI: begin
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    busy_n = (state_n != S_IDLE);
  end

  // State, datapath and output registers, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= {AW{1'b0}};
      wr_data_r <= {W{1'b0}};
      carry_r   <= 1'b0;
      zero_r    <= 1'b0;
      dst_r     <= {AW{1'b0}};
      a_r       <= {W{1'b0}};
      b_r       <= {W{1'b0}};
      prod_r    <= {(2*W){1'b0}};
      cnt_r     <= {CW{1'b0}};
    end else begin
      state_r   <= state_n;
      busy_r    <= busy_n;
      done_r    <= done_n;
      wr_en_r   <= wr_en_n;
      wr_addr_r <= wr_addr_n;
      wr_data_r <= wr_data_n;
      carry_r   <= carry_n;
      zero_r    <= zero_n;
      dst_r     <= dst_n;
      a_r       <= a_n;
      b_r       <= b_n;
      prod_r    <= prod_n;
      cnt_r     <= cnt_n;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign wr_en   = wr_en_r;
  assign wr_addr = wr_addr_r;
  assign wr_data = wr_data_r;
  assign carry   = carry_r;
  assign zero    = zero_r;

endmodule
